// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises, debounces, edge-detects and auto-repeats push-buttons,
// and latches press/repeat events per video frame.
module btn_conditioner #(
  parameter int N_BTN            = 5,
  parameter int CLK_HZ           = 100000000,
  parameter int SAMPLE_HZ        = 1000,
  parameter int DEBOUNCE_SAMPLES = 8,
  parameter int REPEAT_DELAY     = 400,
  parameter int REPEAT_PERIOD    = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             frame_strobe,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [N_BTN-1:0] btn_frame
);
  localparam int PRE  = CLK_HZ / SAMPLE_HZ;
  localparam int PW   = PRE > 1 ? $clog2(PRE) : 1;
  localparam int DW   = DEBOUNCE_SAMPLES > 1 ? $clog2(DEBOUNCE_SAMPLES) : 1;
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = RMAX > 1 ? $clog2(RMAX) : 1;
  localparam logic [PW-1:0] PRE_MAX    = PW'(PRE - 1);
  localparam logic [DW-1:0] DB_MAX     = DW'(DEBOUNCE_SAMPLES - 1);
  localparam logic [RW-1:0] DELAY_MAX  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_MAX = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {RELEASED, HELD, REPEATING} rpt_state_e;

  logic [N_BTN-1:0] meta_q, sync_q;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      pre_q  <= '0;
    end else begin
      meta_q <= btn_raw;
      sync_q <= meta_q;
      pre_q  <= pre_d;
    end
  end

  always_comb begin
    tick  = pre_q == PRE_MAX;
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [DW-1:0] db_q, db_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    rpt_state_e    st_q, st_d;
    logic          lvl_q, lvl_d, press_q, press_d, rel_q, rel_d, rpt_q, rpt_d;
    logic          acc_q, acc_d, frm_q, frm_d, flip, ev;

    always_comb begin
      flip    = tick && (sync_q[i] != lvl_q) && (db_q == DB_MAX);
      db_d    = tick ? ((sync_q[i] == lvl_q || db_q == DB_MAX) ? '0 : db_q + 1'b1) : db_q;
      lvl_d   = lvl_q ^ flip;
      press_d = flip && !lvl_q;
      rel_d   = flip && lvl_q;
      st_d    = st_q;
      rcnt_d  = rcnt_q;
      rpt_d   = 1'b0;
      // a level edge always wins over a repeat landing on the same tick
      if (press_d) begin
        st_d   = HELD;
        rcnt_d = '0;
      end else if (rel_d) begin
        st_d   = RELEASED;
        rcnt_d = '0;
      end else if (tick && st_q != RELEASED) begin
        if (rcnt_q == (st_q == HELD ? DELAY_MAX : PERIOD_MAX)) begin
          rpt_d  = 1'b1;
          rcnt_d = '0;
          st_d   = REPEATING;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      ev    = press_q | rpt_q;
      acc_d = frame_strobe ? 1'b0 : acc_q | ev;
      frm_d = frame_strobe ? acc_q | ev : frm_q;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        db_q    <= '0;
        rcnt_q  <= '0;
        st_q    <= RELEASED;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        rpt_q   <= 1'b0;
        acc_q   <= 1'b0;
        frm_q   <= 1'b0;
      end else begin
        db_q    <= db_d;
        rcnt_q  <= rcnt_d;
        st_q    <= st_d;
        lvl_q   <= lvl_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        rpt_q   <= rpt_d;
        acc_q   <= acc_d;
        frm_q   <= frm_d;
      end
    end

    assign btn_level[i]   = lvl_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = rel_q;
    assign btn_repeat[i]  = rpt_q;
    assign btn_frame[i]   = frm_q;
  end
endmodule
